// File: rtl/dff_pipe.sv
// Elastic delay line: DEPTH stages of WIDTH-bit registers with valid/ready handshake,
// bubble collapsing and synchronous flush. Define DFF_PIPE_OCC_EN to add the occ port.
module dff_pipe #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data
`ifdef DFF_PIPE_OCC_EN
   ,
   output logic [$clog2(DEPTH+1)-1:0] occ
`endif
);

   logic [DEPTH-1:0] v;
   logic [DEPTH-1:0] v_nxt;
   logic [DEPTH-1:0] rdy;
   logic [DEPTH-1:0] vin;
   logic [DEPTH-1:0] ld;
   logic [WIDTH-1:0] d [DEPTH];

   // Stage i is ready if it or any stage ahead of it is empty, or the sink takes a word.
   always_comb begin : ready_chain
      logic r;
      r   = out_ready;
      rdy = '0;
      for (int unsigned k = 0; k < DEPTH; k++) begin
         r = r | ~v[DEPTH-1-k];
         rdy[DEPTH-1-k] = r;
      end
   end

   always_comb begin
      vin    = '0;
      vin[0] = in_valid & ~flush;
      for (int unsigned k = 1; k < DEPTH; k++) begin
         vin[k] = v[k-1];
      end
      ld    = rdy & vin;
      v_nxt = flush ? '0 : ((rdy & vin) | (~rdy & v));
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         v <= '0;
         for (int unsigned k = 0; k < DEPTH; k++) begin
            d[k] <= '0;
         end
      end else begin
         v <= v_nxt;
         if (ld[0]) begin
            d[0] <= in_data;
         end
         for (int unsigned k = 1; k < DEPTH; k++) begin
            if (ld[k]) begin
               d[k] <= d[k-1];
            end
         end
      end
   end

   assign in_ready  = rdy[0] & ~flush;
   assign out_valid = v[DEPTH-1];
   assign out_data  = d[DEPTH-1];

`ifdef DFF_PIPE_OCC_EN
   localparam int OW = $clog2(DEPTH + 1);

   logic [OW-1:0] occ_nxt;
   logic [OW-1:0] occ_q;

   always_comb begin
      occ_nxt = '0;
      for (int unsigned k = 0; k < DEPTH; k++) begin
         if (v_nxt[k]) begin
            occ_nxt = occ_nxt + OW'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         occ_q <= '0;
      end else begin
         occ_q <= occ_nxt;
      end
   end

   assign occ = occ_q;
`endif

endmodule

// File: tb/tb_dff_pipe.sv
// Scoreboard bench for dff_pipe: the driver pushes accepted words with their earliest
// arrival time into a queue; a monitor pops on each output transfer and compares.
module tb_dff_pipe;

   localparam int WIDTH = 8;
   localparam int DEPTH = 4;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             flush = 1'b0;
   logic             in_valid = 1'b0;
   logic             in_ready;
   logic [WIDTH-1:0] in_data = '0;
   logic             out_valid;
   logic             out_ready = 1'b0;
   logic [WIDTH-1:0] out_data;
`ifdef DFF_PIPE_OCC_EN
   logic [2:0]       occ;
`endif

   dff_pipe #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
      .clk(clk),
      .rst(rst),
      .flush(flush),
      .in_valid(in_valid),
      .in_ready(in_ready),
      .in_data(in_data),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_data(out_data)
`ifdef DFF_PIPE_OCC_EN
      ,
      .occ(occ)
`endif
   );

   always #5 clk = ~clk;

   // Each word carries the edge it was accepted on and the earliest edge after which
   // it may appear on out_*; a word never overtakes the one ahead of it.
   typedef struct {
      logic [WIDTH-1:0] data;
      int               ready_at;
      int               acc_edge;
   } ent_t;

   ent_t q[$];
   int   ecnt = 0;
   int   n_chk = 0;
   int   n_pass = 0;
   bit   chk_en = 1'b0;
   bit   acc_last = 1'b0;

   always @(posedge clk) ecnt <= ecnt + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at edge %0d", name, act, exp, ecnt);
   endtask

   // One cycle of stimulus: drive just after the edge, check in_ready, record acceptance.
   task automatic step(input logic iv, input logic [WIDTH-1:0] dat, input logic ordy,
                       input logic fl, input logic rs);
      int exp_rdy;
      @(posedge clk);
      #1;
      in_valid  = iv;
      in_data   = dat;
      out_ready = ordy;
      flush     = fl;
      rst       = rs;
      #1;
      acc_last = 1'b0;
      if (chk_en && !rs) begin
         exp_rdy = (!fl && (q.size() < DEPTH || ordy)) ? 1 : 0;
         chk("in_ready", 32'(in_ready), 32'(exp_rdy));
         if (iv && in_ready) begin
            q.push_back('{data: dat, ready_at: ecnt + DEPTH, acc_edge: ecnt + 1});
            acc_last = 1'b1;
         end
      end
      #2;
      if (fl || rs) q.delete();
   endtask

   // Monitor: compares outputs against the scoreboard just after every edge.
   initial begin
      logic             prv_rst, prv_fl, prv_ov, prv_or;
      logic [WIDTH-1:0] prv_od;
      bit               exp_ov;
      int               n_in;
      ent_t             h;
      prv_rst = 1'b1; prv_fl = 1'b0; prv_ov = 1'b0; prv_or = 1'b0; prv_od = '0;
      forever begin
         @(posedge clk);
         #3;
         if (chk_en) begin
            exp_ov = (q.size() > 0) && (ecnt >= q[0].ready_at);
            chk("out_valid", 32'(out_valid), 32'(exp_ov));
            if (exp_ov) chk("out_data", 32'(out_data), 32'(q[0].data));
            if (prv_rst) chk("out_data_after_rst", 32'(out_data), 32'(0));
            if (prv_ov && !prv_or && !prv_rst && !prv_fl) begin
               chk("hold_valid", 32'(out_valid), 32'(1));
               chk("hold_data", 32'(out_data), 32'(prv_od));
            end
`ifdef DFF_PIPE_OCC_EN
            n_in = 0;
            foreach (q[i]) if (q[i].acc_edge <= ecnt) n_in++;
            chk("occ", 32'(occ), 32'(n_in));
`endif
            if (out_valid && out_ready && exp_ov && !rst) begin
               void'(q.pop_front());
               if (q.size() > 0) begin
                  h = q[0];
                  if (h.ready_at < ecnt + 1) h.ready_at = ecnt + 1;
                  q[0] = h;
               end
            end
         end
         prv_rst = rst; prv_fl = flush; prv_ov = out_valid; prv_or = out_ready; prv_od = out_data;
      end
   end

   task automatic idle(input int n, input logic ordy);
      for (int i = 0; i < n; i++) step(1'b0, '0, ordy, 1'b0, 1'b0);
   endtask

   initial begin
      int idx;
      step(1'b0, '0, 1'b1, 1'b0, 1'b1);
      step(1'b0, '0, 1'b1, 1'b0, 1'b1);
      chk_en = 1'b1;

      // Single word latency
      step(1'b1, 8'hA5, 1'b1, 1'b0, 1'b0);
      idle(8, 1'b1);

      // Back-to-back streaming
      for (int i = 0; i < 16; i++) step(1'b1, 8'(i), 1'b1, 1'b0, 1'b0);
      idle(8, 1'b1);

      // Fill and stall, then release
      idx = 0;
      for (int c = 0; c < 40 && idx < 6; c++) begin
         step(1'b1, 8'(idx), (c >= 8), 1'b0, 1'b0);
         if (acc_last) idx++;
      end
      chk("fill_all_accepted", 32'(idx), 32'(6));
      idle(8, 1'b1);

      // Full passthrough
      for (int i = 0; i < 4; i++) step(1'b1, 8'(8'h40 + i), 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 8; i++) step(1'b1, 8'(8'h50 + i), 1'b1, 1'b0, 1'b0);
      idle(8, 1'b1);

      // Bubble collapse
      step(1'b1, 8'h11, 1'b1, 1'b0, 1'b0);
      step(1'b0, '0, 1'b0, 1'b0, 1'b0);
      step(1'b1, 8'h22, 1'b0, 1'b0, 1'b0);
      idle(4, 1'b0);
      idle(6, 1'b1);

      // Flush with three words held and input offered
      for (int i = 0; i < 3; i++) step(1'b1, 8'(8'h60 + i), 1'b0, 1'b0, 1'b0);
      step(1'b1, 8'h77, 1'b0, 1'b1, 1'b0);
      idle(6, 1'b1);

      // Reset with three words held and input offered
      for (int i = 0; i < 3; i++) step(1'b1, 8'(8'h70 + i), 1'b0, 1'b0, 1'b0);
      step(1'b1, 8'h88, 1'b0, 1'b0, 1'b1);
      idle(6, 1'b1);

      // Randomised traffic with occasional flush and reset
      for (int i = 0; i < 3000; i++) begin
         step(1'($urandom_range(0, 3) != 0), 8'($urandom), 1'($urandom_range(0, 2) != 0),
              1'($urandom_range(0, 63) == 0), 1'($urandom_range(0, 127) == 0));
      end

      idle(3 * DEPTH + 5, 1'b1);
      chk("drained", 32'(q.size()), 32'(0));
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
